mem_alloc_ctrl: RTL and testbench
=================================

Name: mem_alloc_ctrl

Overview:
- Sequencing controller for the dynamic-memory slot pool.
- Owns the NROWS x NCOLS occupancy bitmap; one bit per slot, 1 = used.
- Arbitrates alloc/free requests from NREQ requesters round-robin. For an alloc, finds the lowest free row in the requested column, marks it used and returns the row. For a free, clears the slot.
- Sits between client engines and the slot storage; single op in flight.

Parameters:
- NREQ, 4, number of requesters; power of 2, 2..8.
- NROWS, 6, rows per column; max 8.
- NCOLS, 6, columns (banks); max 8.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request pending.
- req_op  in  NREQ  per-requester op: 0 = alloc, 1 = free.
- req_col  in  NREQ*3  per-requester column index; requester i occupies bits [3i+2:3i].
- req_row  in  NREQ*3  per-requester row index; used for free only.
- req_ready  out  NREQ  one-hot accept pulse.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_id  out  $clog2(NREQ)  requester index of the response.
- rsp_row  out  3  allocated row (alloc) or echoed row (free).
- rsp_ok  out  1  1 = success; 0 = full, double free or out-of-range index.
- busy  out  1  FSM not in IDLE.
- col_full  out  NCOLS  bit c = 1 when every row of column c is used; combinational from the bitmap.

Behaviour:
- Reset: all outputs 0, bitmap all free, FSM in IDLE, RR pointer 0. Reset is applied asynchronously; any in-flight op is discarded and produces no response.
- FSM states:
  - IDLE: if any req_valid, grant per round-robin. req_ready[g] is combinational and high this cycle. Capture id, op, col and row; go to LOOKUP.
  - LOOKUP: register the lowest row r with bitmap[r][col] == 0, plus a found flag. Go to COMMIT.
  - COMMIT: alloc+found sets the bit; free+bit==1 clears it. Results are registered; go to IDLE.
  - IDLE (next cycle): rsp_valid = 1 for exactly one cycle. A new grant may occur in the same cycle.
- Latency: grant at T, rsp_valid at T+3; maximum throughput is one op per 3 cycles.
- Round-robin: search starts at last_grant+1 and wraps modulo NREQ. After reset the search starts at 0. The pointer updates only on a grant.
- Handshake:
  - The requester holds req_valid, op, col and row stable until req_ready.
  - Deasserting req_valid before grant is legal; no side effects.
- Alloc failure when the column is full: rsp_ok = 0, rsp_row = 0, bitmap unchanged.
- Free of a slot that is already free: rsp_ok = 0, bitmap unchanged.
- Out-of-range index (col >= NCOLS, or free with row >= NROWS): rsp_ok = 0, no bitmap change.
- No response backpressure; consumers must sample rsp_valid.
- Bitmap is modified only in COMMIT; col_full reflects the post-COMMIT state from T+3.

Optional Feature:
- Macro: MEM_ALLOC_STATS_EN.
- Defined:
  - Adds output used_cnt (width $clog2(NROWS*NCOLS+1)), the total used slots; +1 on successful alloc, -1 on successful free, updated at COMMIT.
  - Adds output fail_cnt (16 bits), incremented on every rsp_ok == 0 and saturating at 0xFFFF.
  - Both counters reset to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Package mem_alloc_pkg: op encoding (OP_ALLOC = 0, OP_FREE = 1), FSM state enum (IDLE, LOOKUP, COMMIT), index width constant (3).
- Sub-module free_row_finder: combinational. Inputs: NROWS-bit column occupancy vector. Outputs: lowest zero index and found flag. Instantiated once, fed by the column selected from the bitmap.

Test Plan:
- Post-reset alloc: req 0 alloc col 2 at T -> req_ready = 0001 at T; rsp_valid at T+3 with id 0, row 0, ok 1; then alloc col 2 again -> row 1.
- Fill column: 6 allocs to col 5 -> rows 0..5 ok, col_full[5] = 1; 7th alloc -> ok 0, row 0; with STATS_EN, fail_cnt = 1 and used_cnt = 6.
- Free/realloc: after rows 0..2 allocated in col 0, free row 1 -> ok 1; next alloc col 0 -> row 1. Freeing row 1 twice -> second ok 0.
- Fairness: all 4 req_valid held with alloc col 0 -> grants in order 0, 1, 2, 3, 0, spaced 3 cycles; rsp_ids match the grant order.
- Range check: alloc col 7 -> ok 0; free col 1 row 6 -> ok 0; bitmap unchanged and col_full stays 0.
- Async reset: assert rst_n low during LOOKUP -> no rsp_valid, busy = 0, bitmap empty; after release, first grant goes to requester 0.

Source files
------------

// File: rtl/mem_alloc_pkg.sv
// Shared encodings for the slot-pool allocation controller: op codes, FSM states
// and the fixed 3-bit row/column index width.
package mem_alloc_pkg;

   localparam int IDX_W = 3;

   typedef enum logic {
      OP_ALLOC = 1'b0,
      OP_FREE  = 1'b1
   } op_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOOKUP = 2'd1,
      COMMIT = 2'd2
   } state_e;

endpackage

// File: rtl/mem_alloc_ctrl_free_row_finder.sv
// Combinational priority search: lowest clear bit of a column occupancy vector.
module free_row_finder
   import mem_alloc_pkg::*;
#(
   parameter int NROWS = 6
) (
   input  logic [NROWS-1:0] occ,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   // Scanning downward lets the lowest free row win the last assignment.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int r = NROWS - 1; r >= 0; r--) begin
         if (!occ[r]) begin
            idx   = IDX_W'(r);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_alloc_ctrl.sv
// Slot-pool allocation controller: round-robin grant, lowest-free-row alloc, free.
// Optional occupancy/failure counters are built when MEM_ALLOC_STATS_EN is defined.
module mem_alloc_ctrl
   import mem_alloc_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int NROWS = 6,
   parameter int NCOLS = 6
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NREQ-1:0]               req_valid,
   input  logic [NREQ-1:0]               req_op,
   input  logic [NREQ*IDX_W-1:0]         req_col,
   input  logic [NREQ*IDX_W-1:0]         req_row,
   output logic [NREQ-1:0]               req_ready,
   output logic                          rsp_valid,
   output logic [$clog2(NREQ)-1:0]       rsp_id,
   output logic [IDX_W-1:0]              rsp_row,
   output logic                          rsp_ok,
   output logic                          busy,
   output logic [NCOLS-1:0]              col_full
`ifdef MEM_ALLOC_STATS_EN
   ,
   output logic [$clog2(NROWS*NCOLS+1)-1:0] used_cnt,
   output logic [15:0]                   fail_cnt
`endif
);

   localparam int ID_W = $clog2(NREQ);
   localparam logic [IDX_W:0] NROWS_L = (IDX_W + 1)'(NROWS);
   localparam logic [IDX_W:0] NCOLS_L = (IDX_W + 1)'(NCOLS);

   state_e                         state_q, state_d;
   logic [ID_W-1:0]                ptr_q, ptr_d, id_q, id_d, rsp_id_q, rsp_id_d;
   op_e                            op_q, op_d;
   logic [IDX_W-1:0]               col_q, col_d, row_q, row_d;
   logic [IDX_W-1:0]               fr_row_q, fr_row_d, rsp_row_q, rsp_row_d;
   logic                           fr_found_q, fr_found_d;
   logic                           rsp_valid_q, rsp_valid_d, rsp_ok_q, rsp_ok_d;
   logic [NCOLS-1:0][NROWS-1:0]    bmp_q, bmp_d;

   logic                           gnt_vld, gnt_op;
   logic [ID_W-1:0]                gnt_idx, cand;
   logic [IDX_W-1:0]               gnt_col, gnt_row, fr_idx, wr_row;
   logic [NROWS-1:0]               col_vec;
   logic                           fr_found, occ_bit, col_in, row_in, commit_ok, wr_val;

   // Round-robin search starting at the slot after the last grant.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = ptr_q + ID_W'(k);
         if (!gnt_vld && req_valid[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand;
         end
      end
      gnt_op  = 1'b0;
      gnt_col = '0;
      gnt_row = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (ID_W'(i) == gnt_idx) begin
            gnt_op  = req_op[i];
            gnt_col = req_col[IDX_W*i +: IDX_W];
            gnt_row = req_row[IDX_W*i +: IDX_W];
         end
      end
      req_ready = '0;
      if (state_q == IDLE && gnt_vld) req_ready[gnt_idx] = 1'b1;
   end

   // An out-of-range column reads as fully occupied so nothing is ever found there.
   always_comb begin
      col_vec = '1;
      for (int c = 0; c < NCOLS; c++) begin
         if (IDX_W'(c) == col_q) col_vec = bmp_q[c];
      end
      occ_bit = 1'b0;
      for (int r = 0; r < NROWS; r++) begin
         if (IDX_W'(r) == row_q) occ_bit = col_vec[r];
      end
      col_in = ({1'b0, col_q} < NCOLS_L);
      row_in = ({1'b0, row_q} < NROWS_L);
      for (int c = 0; c < NCOLS; c++) col_full[c] = &bmp_q[c];
   end

   free_row_finder #(.NROWS(NROWS)) u_finder (
      .occ   (col_vec),
      .idx   (fr_idx),
      .found (fr_found)
   );

   always_comb begin
      if (op_q == OP_ALLOC) begin
         commit_ok = fr_found_q;
         wr_row    = fr_row_q;
         wr_val    = 1'b1;
      end else begin
         commit_ok = col_in && row_in && occ_bit;
         wr_row    = row_q;
         wr_val    = 1'b0;
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      id_d        = id_q;
      op_d        = op_q;
      col_d       = col_q;
      row_d       = row_q;
      fr_row_d    = fr_row_q;
      fr_found_d  = fr_found_q;
      bmp_d       = bmp_q;
      rsp_valid_d = 1'b0;
      rsp_ok_d    = rsp_ok_q;
      rsp_row_d   = rsp_row_q;
      rsp_id_d    = rsp_id_q;
      case (state_q)
         IDLE: begin
            if (gnt_vld) begin
               id_d    = gnt_idx;
               op_d    = gnt_op ? OP_FREE : OP_ALLOC;
               col_d   = gnt_col;
               row_d   = gnt_row;
               ptr_d   = gnt_idx + 1'b1;
               state_d = LOOKUP;
            end
         end
         LOOKUP: begin
            fr_row_d   = fr_idx;
            fr_found_d = fr_found && col_in;
            state_d    = COMMIT;
         end
         COMMIT: begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = id_q;
            rsp_ok_d    = commit_ok;
            rsp_row_d   = (op_q == OP_FREE) ? row_q : (commit_ok ? fr_row_q : '0);
            if (commit_ok) begin
               for (int c = 0; c < NCOLS; c++) begin
                  for (int r = 0; r < NROWS; r++) begin
                     if (IDX_W'(c) == col_q && IDX_W'(r) == wr_row) bmp_d[c][r] = wr_val;
                  end
               end
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         bmp_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_ok_q    <= 1'b0;
         rsp_row_q   <= '0;
         rsp_id_q    <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         bmp_q       <= bmp_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_ok_q    <= rsp_ok_d;
         rsp_row_q   <= rsp_row_d;
         rsp_id_q    <= rsp_id_d;
      end
   end

   always_ff @(posedge clk) begin
      id_q       <= id_d;
      op_q       <= op_d;
      col_q      <= col_d;
      row_q      <= row_d;
      fr_row_q   <= fr_row_d;
      fr_found_q <= fr_found_d;
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_row   = rsp_row_q;
   assign rsp_ok    = rsp_ok_q;
   assign busy      = (state_q != IDLE);

`ifdef MEM_ALLOC_STATS_EN
   localparam int CNT_W = $clog2(NROWS*NCOLS+1);
   logic [CNT_W-1:0] used_q, used_d;
   logic [15:0]      fail_q, fail_d;

   always_comb begin
      used_d = used_q;
      fail_d = fail_q;
      if (state_q == COMMIT) begin
         if (commit_ok) used_d = (op_q == OP_ALLOC) ? used_q + 1'b1 : used_q - 1'b1;
         else if (fail_q != 16'hFFFF) fail_d = fail_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         used_q <= '0;
         fail_q <= '0;
      end else begin
         used_q <= used_d;
         fail_q <= fail_d;
      end
   end

   assign used_cnt = used_q;
   assign fail_cnt = fail_q;
`endif

endmodule

// File: tb/tb_mem_alloc_ctrl.sv
// Bench for mem_alloc_ctrl: vector table, corner sequences, randomized ops vs model.
module tb_mem_alloc_ctrl;
   localparam int NREQ = 4, NROWS = 6, NCOLS = 6;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic [3:0]  req_valid = '0, req_op = '0, req_ready;
   logic [11:0] req_col = '0, req_row = '0;
   logic        rsp_valid, rsp_ok, busy;
   logic [1:0]  rsp_id;
   logic [2:0]  rsp_row;
   logic [5:0]  col_full;
`ifdef MEM_ALLOC_STATS_EN
   logic [5:0]  used_cnt;
   logic [15:0] fail_cnt;
`endif

   mem_alloc_ctrl #(.NREQ(NREQ), .NROWS(NROWS), .NCOLS(NCOLS)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
      .req_col(req_col), .req_row(req_row), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_row(rsp_row), .rsp_ok(rsp_ok),
      .busy(busy), .col_full(col_full)
`ifdef MEM_ALLOC_STATS_EN
      , .used_cnt(used_cnt), .fail_cnt(fail_cnt)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0, failures = 0;
   int exp_used = 0, exp_fail = 0;
   bit ref_bmp [8][8];

   typedef struct {
      int id; int op; int col; int row; int ok; int erow;
   } vec_t;
   vec_t tbl [12];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   function automatic void clear_model();
      for (int c = 0; c < 8; c++) for (int r = 0; r < 8; r++) ref_bmp[c][r] = 1'b0;
      exp_used = 0;
      exp_fail = 0;
   endfunction

   // Expected outcome straight from the allocation rules.
   function automatic void model(input int op, input int col, input int row,
                                 output int ok, output int erow);
      ok = 0;
      erow = 0;
      if (op == 0) begin
         if (col < NCOLS)
            for (int r = 0; r < NROWS; r++)
               if (ok == 0 && !ref_bmp[col][r]) begin ok = 1; erow = r; end
      end else begin
         erow = row;
         ok = (col < NCOLS && row < NROWS && ref_bmp[col][row]) ? 1 : 0;
      end
   endfunction

   function automatic int ref_full();
      int f = 0;
      for (int c = 0; c < NCOLS; c++) begin
         bit all = 1'b1;
         for (int r = 0; r < NROWS; r++) if (!ref_bmp[c][r]) all = 1'b0;
         if (all) f |= (1 << c);
      end
      return f;
   endfunction

   task automatic do_reset();
      @(posedge clk);
      #1 rst_n = 1'b0;
      req_valid = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      clear_model();
   endtask

   task automatic wait_rsp(output int rid, output int rrow, output int rok, output int lat);
      lat = 0; rid = -1; rrow = -1; rok = -1;
      do begin
         @(negedge clk);
         lat++;
      end while (!rsp_valid && lat < 10);
      if (rsp_valid) begin
         rid = int'(rsp_id); rrow = int'(rsp_row); rok = int'(rsp_ok);
      end
   endtask

   task automatic issue(input int id, input int op, input int col, input int row,
                        output int rid, output int rrow, output int rok,
                        output int rdy, output int lat);
      int n = 0;
      req_op[id] = op[0];
      req_col[3*id +: 3] = 3'(col);
      req_row[3*id +: 3] = 3'(row);
      req_valid = 4'(1 << id);
      @(negedge clk);
      while (req_ready == 4'd0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      rdy = int'(req_ready);
      @(posedge clk);
      #1 req_valid = '0;
      wait_rsp(rid, rrow, rok, lat);
      @(negedge clk);
      chk("rsp_pulse", 32'(rsp_valid), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input string tag, input int id, input int op, input int col,
                         input int row, input int eok, input int erow);
      int rid, rrow, rok, rdy, lat;
      issue(id, op, col, row, rid, rrow, rok, rdy, lat);
      chk({tag, ".ready"}, rdy, 1 << id);
      chk({tag, ".lat"}, lat, 3);
      chk({tag, ".id"}, rid, id);
      chk({tag, ".ok"}, rok, eok);
      chk({tag, ".row"}, rrow, erow);
      if (eok != 0) begin
         if (op == 0) begin ref_bmp[col][erow] = 1'b1; exp_used++; end
         else begin ref_bmp[col][row] = 1'b0; exp_used--; end
      end else exp_fail++;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int g_ids[$], g_cyc[$], r_ids[$], r_rows[$];
      int cyc, rid, rrow, rok, lat, eok, erow;
      int id, op, col, row;

      tbl[0]  = '{0, 0, 2, 0, 1, 0};
      tbl[1]  = '{1, 0, 2, 0, 1, 1};
      tbl[2]  = '{2, 0, 0, 0, 1, 0};
      tbl[3]  = '{3, 0, 0, 0, 1, 1};
      tbl[4]  = '{0, 0, 0, 0, 1, 2};
      tbl[5]  = '{1, 1, 0, 1, 1, 1};
      tbl[6]  = '{2, 0, 0, 0, 1, 1};
      tbl[7]  = '{3, 1, 0, 1, 1, 1};
      tbl[8]  = '{0, 1, 0, 1, 0, 1};
      tbl[9]  = '{1, 0, 7, 0, 0, 0};
      tbl[10] = '{2, 1, 1, 6, 0, 6};
      tbl[11] = '{3, 0, 6, 0, 0, 0};

      // Reset state
      #12;
      chk("rst.rsp_valid", 32'(rsp_valid), 0);
      chk("rst.rsp_ok", 32'(rsp_ok), 0);
      chk("rst.rsp_row", 32'(rsp_row), 0);
      chk("rst.rsp_id", 32'(rsp_id), 0);
      chk("rst.busy", 32'(busy), 0);
      chk("rst.col_full", 32'(col_full), 0);
      chk("rst.req_ready", 32'(req_ready), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      clear_model();

      // Vector table: post-reset alloc, free/realloc, double free, range checks
      for (int i = 0; i < 12; i++)
         run_op($sformatf("tbl%0d", i), tbl[i].id, tbl[i].op, tbl[i].col, tbl[i].row,
                tbl[i].ok, tbl[i].erow);
      chk("range.col_full", 32'(col_full), 0);

      // Fill column 5, then overflow
      for (int i = 0; i < 7; i++)
         run_op($sformatf("fill%0d", i), i % 4, 0, 5, 0, (i < 6) ? 1 : 0, (i < 6) ? i : 0);
      chk("fill.col_full", 32'(col_full), 32'(ref_full()));
      chk("fill.col5", 32'(col_full[5]), 1);
`ifdef MEM_ALLOC_STATS_EN
      chk("fill.used_cnt", 32'(used_cnt), exp_used);
      chk("fill.fail_cnt", 32'(fail_cnt), exp_fail);
`endif

      // Fairness: all requesters hold alloc col 1
      do_reset();
      req_op = '0;
      req_col = {3'd1, 3'd1, 3'd1, 3'd1};
      req_valid = 4'hF;
      cyc = 0;
      while (g_ids.size() < 5 && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (rsp_valid) begin r_ids.push_back(int'(rsp_id)); r_rows.push_back(int'(rsp_row)); end
         if (req_ready != 4'd0) begin
            chk("fair.onehot", 32'($countones(req_ready)), 1);
            for (int k = 0; k < 4; k++) if (req_ready[k]) g_ids.push_back(k);
            g_cyc.push_back(cyc);
         end
      end
      @(posedge clk);
      #1 req_valid = '0;
      repeat (4) begin
         @(negedge clk);
         if (rsp_valid) begin r_ids.push_back(int'(rsp_id)); r_rows.push_back(int'(rsp_row)); end
      end
      chk("fair.grants", g_ids.size(), 5);
      chk("fair.rsps", r_ids.size(), 5);
      for (int i = 0; i < 5; i++) begin
         if (i < g_ids.size()) chk($sformatf("fair.gnt%0d", i), g_ids[i], i % 4);
         if (i > 0 && i < g_cyc.size()) chk($sformatf("fair.gap%0d", i), g_cyc[i] - g_cyc[i-1], 3);
         if (i < r_ids.size()) begin
            chk($sformatf("fair.rid%0d", i), r_ids[i], i % 4);
            chk($sformatf("fair.row%0d", i), r_rows[i], i);
         end
      end
      for (int r = 0; r < 5; r++) ref_bmp[1][r] = 1'b1;
      exp_used += 5;

      // Async reset during LOOKUP
      do_reset();
      run_op("ar.pre", 0, 0, 2, 0, 1, 0);
      req_op[0] = 1'b0;
      req_col[2:0] = 3'd3;
      req_valid = 4'b0001;
      @(negedge clk);
      chk("ar.grant", 32'(req_ready), 1);
      @(posedge clk);
      #1 req_valid = '0;
      #2 rst_n = 1'b0;
      #1;
      chk("ar.busy", 32'(busy), 0);
      chk("ar.rsp_valid", 32'(rsp_valid), 0);
      chk("ar.col_full", 32'(col_full), 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("ar.hold_rsp", 32'(rsp_valid), 0);
         chk("ar.hold_busy", 32'(busy), 0);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      clear_model();
      req_op[1:0] = 2'b00;
      req_col[5:0] = {3'd2, 3'd2};
      req_valid = 4'b0011;
      @(negedge clk);
      chk("ar.first_grant", 32'(req_ready), 1);
      @(posedge clk);
      #1 req_valid = '0;
      wait_rsp(rid, rrow, rok, lat);
      chk("ar.lat", lat, 3);
      chk("ar.id", rid, 0);
      chk("ar.row", rrow, 0);
      chk("ar.ok", rok, 1);
      ref_bmp[2][0] = 1'b1;
      exp_used = 1;
      @(posedge clk);
      #1;

      // Randomized ops against the model
      do_reset();
      for (int i = 0; i < 200; i++) begin
         id  = int'($urandom_range(0, 3));
         op  = ($urandom_range(0, 99) < 55) ? 0 : 1;
         col = ($urandom_range(0, 99) < 90) ? int'($urandom_range(0, 5)) : int'($urandom_range(6, 7));
         row = ($urandom_range(0, 99) < 90) ? int'($urandom_range(0, 5)) : int'($urandom_range(6, 7));
         model(op, col, row, eok, erow);
         run_op($sformatf("rnd%0d", i), id, op, col, row, eok, erow);
         chk($sformatf("rnd%0d.col_full", i), 32'(col_full), 32'(ref_full()));
      end
`ifdef MEM_ALLOC_STATS_EN
      chk("rnd.used_cnt", 32'(used_cnt), exp_used);
      chk("rnd.fail_cnt", 32'(fail_cnt), exp_fail);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
